// File: rtl/counter_ctrl_pkg.sv
// Shared types and limits for the round-robin counter controller.
package counter_ctrl_pkg;

  localparam int unsigned N_REQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_rr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer and wraps.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      w_cand = IW'((int'(i_ptr) + i) % int'(N_REQ));
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/counter_rr_ctrl.sv
// Round-robin controller sharing one counter between N_REQ requesters;
// halts on a reported overflow until cleared.
module counter_rr_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter  int unsigned N_REQ   = 4,
  parameter  int unsigned WIDTH_P = 4,
  localparam int unsigned IW      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH_P-1:0] req_inc,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clr_req,
  output logic                     cnt_en,
  output logic [WIDTH_P-1:0]       cnt_inc,
  output logic                     cnt_clr,
  input  logic                     cnt_overflow,
  output logic                     err_overflow,
  output logic [IW-1:0]            err_owner,
  output logic                     busy
);

  if ((N_REQ < 2) || (N_REQ > N_REQ_MAX)) begin : g_bad_n_req
    $error("counter_rr_ctrl: N_REQ out of range");
  end

  state_t             r_state;
  state_t             w_next;
  logic [IW-1:0]      r_ptr;
  logic               r_err;
  logic [IW-1:0]      r_owner;
  logic               r_busy;

  logic [N_REQ-1:0]   w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [WIDTH_P-1:0] w_sel;
  logic [N_REQ-1:0]   w_ready;
  logic               w_en;
  logic [WIDTH_P-1:0] w_inc;
  logic               w_clr;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Increment of the current winner.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_idx == IW'(i)) w_sel = req_inc[i*WIDTH_P +: WIDTH_P];
    end
  end

  // Next state and the combinational counter/handshake drive.
  always_comb begin
    w_next  = r_state;
    w_ready = '0;
    w_en    = 1'b0;
    w_inc   = '0;
    w_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid) w_next = ISSUE;
      end
      ISSUE: begin
        if (w_any) begin
          w_ready = w_grant;
          w_en    = 1'b1;
          w_inc   = w_sel;
          w_next  = CHECK;
        end else begin
          w_next = IDLE;
        end
      end
      CHECK: begin
        if (cnt_overflow)    w_next = HALT;
        else if (|req_valid) w_next = ISSUE;
        else                 w_next = IDLE;
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
    // A clear overrides any grant and discards a pending overflow check.
    if (clr_req) begin
      w_ready = '0;
      w_en    = 1'b0;
      w_inc   = '0;
      w_clr   = 1'b1;
      w_next  = IDLE;
    end
    if (reset) begin
      w_ready = '0;
      w_en    = 1'b0;
      w_inc   = '0;
      w_clr   = 1'b0;
      w_next  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= IW'(N_REQ - 1);
      r_err   <= 1'b0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ISSUE) || (w_next == CHECK);
      if (w_en) r_ptr <= w_idx;
      if (clr_req) begin
        r_err   <= 1'b0;
        r_owner <= '0;
      end else if ((r_state == CHECK) && cnt_overflow) begin
        r_err   <= 1'b1;
        r_owner <= r_ptr;
      end
    end
  end

  assign req_ready    = w_ready;
  assign cnt_en       = w_en;
  assign cnt_inc      = w_inc;
  assign cnt_clr      = w_clr;
  assign err_overflow = r_err;
  assign err_owner    = r_owner;
  assign busy         = r_busy;

endmodule

// File: tb/tb_counter_rr_ctrl.sv
// Directed bench for counter_rr_ctrl with an attached WIDTH_P-bit counter model.
module tb_counter_rr_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_inc;
  logic [N-1:0]   req_ready;
  logic           clr_req;
  logic           cnt_en;
  logic [W-1:0]   cnt_inc;
  logic           cnt_clr;
  logic           cnt_overflow;
  logic           err_overflow;
  logic [1:0]     err_owner;
  logic           busy;

  logic [W-1:0]   c_val;
  logic           c_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_rr_ctrl #(.N_REQ(N), .WIDTH_P(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_inc      (req_inc),
    .req_ready    (req_ready),
    .clr_req      (clr_req),
    .cnt_en       (cnt_en),
    .cnt_inc      (cnt_inc),
    .cnt_clr      (cnt_clr),
    .cnt_overflow (cnt_overflow),
    .err_overflow (err_overflow),
    .err_owner    (err_owner),
    .busy         (busy)
  );

  // Counter with registered overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_val <= '0;
      c_ovf <= 1'b0;
    end else if (cnt_clr) begin
      c_val <= '0;
      c_ovf <= 1'b0;
    end else if (cnt_en) begin
      {c_ovf, c_val} <= {1'b0, c_val} + {1'b0, cnt_inc};
    end else begin
      c_ovf <= 1'b0;
    end
  end
  assign cnt_overflow = c_ovf;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] inc;
    logic        clr;
    logic [3:0]  ready;
    logic        en;
    logic [3:0]  cinc;
    logic        cclr;
    logic        busy;
    logic        err;
    logic [1:0]  owner;
    logic [3:0]  val;
  } vec_t;

  vec_t tbl[39];

  function automatic vec_t mk(input logic [3:0] valid, input logic [15:0] inc,
                              input logic clr, input logic [3:0] ready,
                              input logic en, input logic [3:0] cinc,
                              input logic cclr, input logic bsy, input logic err,
                              input logic [1:0] owner, input logic [3:0] val);
    vec_t v;
    v.valid = valid; v.inc = inc; v.clr = clr; v.ready = ready; v.en = en;
    v.cinc = cinc; v.cclr = cclr; v.busy = bsy; v.err = err; v.owner = owner;
    v.val = val;
    return v;
  endfunction

  task automatic chk(input string nm, input vec_t e);
    logic [17:0] got;
    logic [17:0] exp;
    got = {req_ready, cnt_en, cnt_inc, cnt_clr, busy, err_overflow, err_owner, c_val};
    exp = {e.ready, e.en, e.cinc, e.cclr, e.busy, e.err, e.owner, e.val};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ready=%b en=%b inc=%h clr=%b busy=%b err=%b owner=%0d val=%0d, expected ready=%b en=%b inc=%h clr=%b busy=%b err=%b owner=%0d val=%0d",
               nm, req_ready, cnt_en, cnt_inc, cnt_clr, busy, err_overflow, err_owner, c_val,
               e.ready, e.en, e.cinc, e.cclr, e.busy, e.err, e.owner, e.val);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    req_inc   = v.inc;
    clr_req   = v.clr;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                 valid  inc      clr  ready en cinc clr busy err own val
    // all valid, inc=1: grant order 0,1,2,3,0
    tbl[0]  = mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tbl[1]  = mk(4'hF, 16'h1111, 1'b0, 4'h1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    tbl[2]  = mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
    tbl[3]  = mk(4'hF, 16'h1111, 1'b0, 4'h2, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
    tbl[4]  = mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd2);
    tbl[5]  = mk(4'hF, 16'h1111, 1'b0, 4'h4, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd2);
    tbl[6]  = mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3);
    tbl[7]  = mk(4'hF, 16'h1111, 1'b0, 4'h8, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3);
    tbl[8]  = mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd4);
    tbl[9]  = mk(4'hF, 16'h1111, 1'b0, 4'h1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd4);
    tbl[10] = mk(4'h0, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd5);
    tbl[11] = mk(4'h0, 16'h1111, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd5);
    // only requester 2 valid with inc=3, neighbours carry other increments
    tbl[12] = mk(4'h4, 16'hA3B5, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tbl[13] = mk(4'h4, 16'hA3B5, 1'b0, 4'h4, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    tbl[14] = mk(4'h4, 16'hA3B5, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3);
    tbl[15] = mk(4'h4, 16'hA3B5, 1'b0, 4'h4, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0, 4'd3);
    tbl[16] = mk(4'h4, 16'hA3B5, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd6);
    tbl[17] = mk(4'h4, 16'hA3B5, 1'b0, 4'h4, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0, 4'd6);
    tbl[18] = mk(4'h0, 16'hA3B5, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd9);
    tbl[19] = mk(4'h0, 16'hA3B5, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd9);
    // bring val to 14, then requester 1 adds 3 -> overflow, HALT
    tbl[20] = mk(4'h1, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd9);
    tbl[21] = mk(4'h1, 16'h0035, 1'b0, 4'h1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'd9);
    tbl[22] = mk(4'h2, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd14);
    tbl[23] = mk(4'h2, 16'h0035, 1'b0, 4'h2, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0, 4'd14);
    tbl[24] = mk(4'h3, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1);
    tbl[25] = mk(4'h3, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1);
    tbl[26] = mk(4'h3, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1);
    // clear out of HALT, grants resume from pointer 1
    tbl[27] = mk(4'h3, 16'h0035, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 4'd1);
    tbl[28] = mk(4'h3, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tbl[29] = mk(4'h3, 16'h0035, 1'b0, 4'h1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    tbl[30] = mk(4'h2, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd5);
    // clear and valid together in ISSUE: no grant
    tbl[31] = mk(4'h2, 16'h0035, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd5);
    tbl[32] = mk(4'h0, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    // overflow seen in CHECK while clear is asserted is discarded
    tbl[33] = mk(4'h2, 16'h00F0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    tbl[34] = mk(4'h2, 16'h00F0, 1'b0, 4'h2, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    tbl[35] = mk(4'h2, 16'h00F0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd15);
    tbl[36] = mk(4'h2, 16'h00F0, 1'b0, 4'h2, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 2'd0, 4'd15);
    tbl[37] = mk(4'h0, 16'h00F0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd14);
    tbl[38] = mk(4'h0, 16'h00F0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Reset held with every requester valid.
    reset     = 1'b1;
    req_valid = 4'hF;
    req_inc   = 16'h1111;
    clr_req   = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset_hold%0d", i),
          mk(4'hF, 16'h1111, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
    end

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 39; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), tbl[i]);
      @(negedge clk);
    end

    // Reset during CHECK after a completed transfer; pointer returns to N-1.
    drive(mk(4'h1, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
    #1;
    chk("rst_mid_idle", mk(4'h1, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
    @(negedge clk);
    #1;
    chk("rst_mid_issue", mk(4'h1, 16'h0035, 1'b0, 4'h1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0));
    @(negedge clk);
    reset   = 1'b1;
    clr_req = 1'b1;
    #1;
    chk("rst_mid_check", mk(4'h1, 16'h0035, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd5));
    @(negedge clk);
    reset   = 1'b0;
    clr_req = 1'b0;
    #1;
    chk("rst_mid_after", mk(4'h1, 16'h0035, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
    @(negedge clk);
    #1;
    chk("rst_mid_regrant", mk(4'h1, 16'h0035, 1'b0, 4'h1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0));
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
